// File: rtl/mem_responder.sv
// Memory-side bus responder: holds each request for LATENCY cycles, then returns a
// one-cycle mem_resp with read data or a byte-masked write, and flags initiator misbehaviour.
module mem_responder #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic        mem_resp,
  output logic [31:0] mem_rdata,
  output logic        mem_err,
  output logic        proto_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam int         DEPTH  = 2 ** ADDR_WIDTH;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [31:0] mem_q [DEPTH];

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  rd_q, rd_d, wr_q, wr_d, err_q, err_d, perr_q, perr_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [31:0]           addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]            be_q, be_d;

  // Request decode straight from the bus, used only at acceptance.
  logic [31:0]           in_off;
  logic                  in_oor;
  logic [ADDR_WIDTH-1:0] in_idx;
  logic                  req;
  logic                  req_changed;
  logic [31:0]           wmerge;

  assign req         = mem_read | mem_write;
  assign in_off      = mem_address - BASE_ADDR;
  assign in_oor      = (mem_address < BASE_ADDR) || ((in_off >> (ADDR_WIDTH + 2)) != 32'd0);
  assign in_idx      = in_off[ADDR_WIDTH+1:2];
  assign req_changed = !req || (mem_read != rd_q) || (mem_write != wr_q) ||
                       (mem_address != addr_q) || (mem_wdata != wdata_q) ||
                       (mem_byte_enable != be_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = err_q;
    perr_d  = perr_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          rd_d    = mem_read;
          wr_d    = mem_write;
          err_d   = in_oor | (mem_read & mem_write);
          idx_d   = in_idx;
          addr_d  = mem_address;
          wdata_d = mem_wdata;
          be_d    = mem_byte_enable;
          cnt_d   = LAT_M1;
          if (mem_read & mem_write) perr_d = 1'b1;
          if (LATENCY == 1) begin
            state_d = RESP;
            if (mem_read) rdata_d = (in_oor | mem_write) ? 32'h0 : mem_q[in_idx];
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (req_changed) perr_d = 1'b1;
        cnt_d = cnt_q - 4'd1;
        // Read data is registered on entry to RESP so it is valid during the pulse.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = RESP;
          if (rd_q) rdata_d = err_q ? 32'h0 : mem_q[idx_q];
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      perr_q  <= 1'b0;
      idx_q   <= '0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      perr_q  <= perr_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    wmerge = mem_q[idx_q];
    for (int i = 0; i < 4; i++)
      if (be_q[i]) wmerge[8*i +: 8] = wdata_q[8*i +: 8];
  end

  // Writes commit on the edge leaving RESP, so a reset during RESP drops them.
  always_ff @(posedge clk) begin
    if (!rst && state_q == RESP && wr_q && !err_q)
      mem_q[idx_q] <= wmerge;
  end

  assign mem_resp  = (state_q == RESP);
  assign mem_err   = (state_q == RESP) & err_q;
  assign mem_rdata = rdata_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances (LATENCY 2 / 1 / 5, the last with
// BASE_ADDR 0x1000); expectations are pushed at issue time and checked by a monitor.
module tb_mem_responder;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2:0]        rd_i = '0, wr_i = '0;
  logic [2:0][3:0]   be_i = '0;
  logic [2:0][31:0]  addr_i = '0, wd_i = '0;
  logic [2:0]        resp_o, err_o, perr_o;
  logic [2:0][31:0]  rdata_o;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int          k;
    int          cyc;
    logic [31:0] rdata;
    bit          ck;
    bit          err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .mem_read(rd_i[0]), .mem_write(wr_i[0]),
    .mem_byte_enable(be_i[0]), .mem_address(addr_i[0]), .mem_wdata(wd_i[0]),
    .mem_resp(resp_o[0]), .mem_rdata(rdata_o[0]), .mem_err(err_o[0]), .proto_err(perr_o[0]));

  mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .mem_read(rd_i[1]), .mem_write(wr_i[1]),
    .mem_byte_enable(be_i[1]), .mem_address(addr_i[1]), .mem_wdata(wd_i[1]),
    .mem_resp(resp_o[1]), .mem_rdata(rdata_o[1]), .mem_err(err_o[1]), .proto_err(perr_o[1]));

  mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h1000), .LATENCY(5)) u_l5 (
    .clk(clk), .rst(rst), .mem_read(rd_i[2]), .mem_write(wr_i[2]),
    .mem_byte_enable(be_i[2]), .mem_address(addr_i[2]), .mem_wdata(wd_i[2]),
    .mem_resp(resp_o[2]), .mem_rdata(rdata_o[2]), .mem_err(err_o[2]), .proto_err(perr_o[2]));

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every mem_resp must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (resp_o[k] === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_resp", 32'(k), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_dut", 32'(k), 32'(e.k));
          chk("resp_cycle", 32'(cyc), 32'(e.cyc));
          chk("resp_err", 32'(err_o[k]), 32'(e.err));
          if (e.ck) chk("resp_rdata", rdata_o[k], e.rdata);
        end
      end
    end
  end

  // Called and returns at posedge+1; request held until the cycle after mem_resp.
  task automatic do_op(input int k, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b, input logic [31:0] er,
                       input bit ck, input bit ee, input int chg = 0,
                       input logic [31:0] alt = 32'h0);
    exp_t e;
    bit   seen;
    seen    = 1'b0;
    e.k     = k;
    e.cyc   = cyc + lat_of(k);
    e.rdata = er;
    e.ck    = ck;
    e.err   = ee;
    sb.push_back(e);
    rd_i[k] = r; wr_i[k] = w; addr_i[k] = a; wd_i[k] = d; be_i[k] = b;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(posedge clk); #1;
      if (n == chg) addr_i[k] = alt;
      @(negedge clk);
      seen = resp_o[k];
    end
    if (!seen) chk("resp_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    rd_i[k] = 1'b0; wr_i[k] = 1'b0;
  endtask

  int t0, t1;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_resp", 32'(resp_o[k]), 32'd0);
      chk("rst_rdata", rdata_o[k], 32'd0);
      chk("rst_err", 32'(err_o[k]), 32'd0);
      chk("rst_perr", 32'(perr_o[k]), 32'd0);
    end
    @(posedge clk); #1;

    // LATENCY=2, BASE 0
    do_op(0, 1, 0, 32'h20, 32'h0, 4'hF, 32'h0, 0, 0);               // write-read prep
    do_op(0, 0, 1, 32'h20, 32'h0, 4'hF, 32'h0, 0, 0);               // clear 0x20
    do_op(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, 0);
    do_op(0, 1, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1, 0);
    do_op(0, 0, 1, 32'h10, 32'h11223344, 4'b0101, 32'hDEADBEEF, 1, 0); // write keeps rdata
    do_op(0, 1, 0, 32'h10, 32'h0, 4'hF, 32'hDE22BE44, 1, 0);
    do_op(0, 0, 1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'h0, 0, 0);
    do_op(0, 1, 0, 32'h13, 32'h0, 4'h0, 32'hDE22BE44, 1, 0);        // misaligned
    chk("perr_clean_l2", 32'(perr_o[0]), 32'd0);

    // Reset while the write sits in WAIT
    rd_i[0] = 1'b0; wr_i[0] = 1'b1; addr_i[0] = 32'h20; wd_i[0] = 32'hCAFEF00D; be_i[0] = 4'hF;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; wr_i[0] = 1'b0;
    @(negedge clk);
    chk("midrst_resp", 32'(resp_o[0]), 32'd0);
    chk("midrst_rdata", rdata_o[0], 32'd0);
    chk("midrst_err", 32'(err_o[0]), 32'd0);
    chk("midrst_perr", 32'(perr_o[0]), 32'd0);
    @(posedge clk); #1;
    do_op(0, 1, 0, 32'h20, 32'h0, 4'h0, 32'h0, 1, 0);

    // Read and write together
    do_op(0, 1, 1, 32'h10, 32'h55555555, 4'hF, 32'h0, 1, 1);
    chk("rw_perr", 32'(perr_o[0]), 32'd1);
    do_op(0, 1, 0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 1, 0);        // no write happened
    chk("rw_perr_sticky", 32'(perr_o[0]), 32'd1);

    // LATENCY=1: back-to-back every 2 cycles
    do_op(1, 0, 1, 32'h40, 32'hA5A5A5A5, 4'hF, 32'h0, 0, 0);
    t0 = cyc;
    do_op(1, 1, 0, 32'h40, 32'h0, 4'h0, 32'hA5A5A5A5, 1, 0);
    t1 = cyc;
    do_op(1, 1, 0, 32'h1000, 32'h0, 4'h0, 32'h0, 1, 1);             // past 4 KiB
    chk("b2b_spacing", 32'(t1 - t0), 32'd2);

    // LATENCY=5, BASE 0x1000: range handling
    do_op(2, 1, 0, 32'h0FFC, 32'h0, 4'h0, 32'h0, 1, 1);
    do_op(2, 0, 1, 32'h1000, 32'h12345678, 4'hF, 32'h0, 1, 0);
    do_op(2, 0, 1, 32'h2000, 32'hFFFFFFFF, 4'hF, 32'h0, 1, 1);
    do_op(2, 1, 0, 32'h1000, 32'h0, 4'h0, 32'h12345678, 1, 0);
    do_op(2, 0, 1, 32'h1FFC, 32'h0BADF00D, 4'hF, 32'h0, 0, 0);
    do_op(2, 1, 0, 32'h1FFC, 32'h0, 4'h0, 32'h0BADF00D, 1, 0);
    chk("perr_clean_l5", 32'(perr_o[2]), 32'd0);

    // Address moves during WAIT: completes at original address
    do_op(2, 1, 0, 32'h1000, 32'h0, 4'h0, 32'h12345678, 1, 0, 2, 32'h1FFC);
    chk("addr_chg_perr", 32'(perr_o[2]), 32'd1);
    chk("addr_chg_other_dut", 32'(perr_o[1]), 32'd0);

    repeat (3) @(posedge clk);
    #1 chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the processor's memory bus: accepts mem_read/mem_write requests from the core, holds them for a programmable latency, then returns a single-cycle mem_resp with read data or a committed byte-masked write. Backing store is an internal word array. Used as the memory model in core-level simulation and as on-chip RAM in FPGA builds. Also checks bus protocol and flags violations by the initiator.

Parameters:
ADDR_WIDTH, 10, word-index width; store holds 2**ADDR_WIDTH 32-bit words (4 KiB default)
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned
LATENCY, 2, cycles from request acceptance to mem_resp; legal range 1..15

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous reset, active-high
mem_read  input  1  read request, held by core until mem_resp
mem_write  input  1  write request, held by core until mem_resp
mem_byte_enable  input  4  write lane mask; bit i enables bits [8i+7:8i]
mem_address  input  32  byte address; bits [1:0] ignored
mem_wdata  input  32  write data
mem_resp  output  1  one-cycle completion pulse
mem_rdata  output  32  read data, valid in mem_resp cycle, held after
mem_err  output  1  one-cycle pulse coincident with mem_resp for an errored transaction
proto_err  output  1  sticky initiator-protocol violation flag

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high; sampled on clk rising edge.
- Reset values: mem_resp=0, mem_rdata=0, mem_err=0, proto_err=0, state=IDLE, counter=0. Array contents are not cleared by rst.
- States: IDLE, WAIT, RESP.
- IDLE: if mem_read|mem_write is high at an edge, capture address/wdata/byte_enable/op and go to WAIT with counter=LATENCY-1. If LATENCY=1, go directly to RESP.
- WAIT: decrement counter each cycle. Go to RESP when the counter reaches 0.
- Resulting latency: a request first seen in cycle t gets mem_resp high in cycle t+LATENCY, for exactly one cycle.
- RESP (mem_resp=1):
  - Read: mem_rdata = word at captured index.
  - Write: commit lanes enabled in captured byte_enable at this edge.
  - Always return to IDLE next.
- Throughput: the core deasserts its request the cycle after mem_resp. A request seen in cycle t+LATENCY+1 starts a new transaction. Back-to-back rate is one transaction per LATENCY+1 cycles.
- There is no combinational path from request inputs to mem_resp.
- Index = (mem_address - BASE_ADDR) >> 2. Out of range when mem_address < BASE_ADDR or index >= 2**ADDR_WIDTH. Out-of-range handling:
  - still respond (the core must never hang);
  - reads return 32'h0;
  - writes are dropped;
  - mem_err=1 with mem_resp.
- mem_read and mem_write both high at acceptance: respond, no write, mem_rdata=0, mem_err=1, proto_err set.
- Write with byte_enable=4'b0000: respond normally, array unchanged, no error.
- For reads, byte_enable is ignored; the full word is returned.
- Misaligned address (bits [1:0] != 0): accessed as the aligned word; no error.
- In WAIT, the initiator must hold the request. If the request drops, or address/op/wdata/byte_enable change versus the captured values:
  - set proto_err;
  - complete using the captured values.
- proto_err is cleared only by rst.
- mem_rdata holds its last value outside mem_resp cycles. Write responses do not alter mem_rdata.
- Reset mid-transaction (rst in WAIT or RESP):
  - abort to IDLE;
  - no write committed;
  - mem_resp stays 0 in the following cycle.

Test Plan:
- Write then read: LATENCY=2. Write addr 0x10, wdata 0xDEADBEEF, be 4'hF, asserted cycle 0 -> mem_resp=1 in cycle 2 only. Read 0x10 issued cycle 3 -> mem_resp in cycle 5 with mem_rdata=0xDEADBEEF, mem_err=0.
- Partial write: prior word 0xDEADBEEF at 0x10. Write wdata 0x11223344, be 4'b0101 -> read returns 0xDE22BE44. Write with be 4'b0000 -> read still 0xDE22BE44.
- Latency sweep: LATENCY=1 -> resp in cycle t+1. LATENCY=5 -> resp in cycle t+5, never earlier. Back-to-back reads with LATENCY=1 complete every 2 cycles.
- Range errors: BASE_ADDR=0x1000, ADDR_WIDTH=10.
  - Read 0x0FFC -> rdata=0, mem_err=1.
  - Write 0x2000 -> mem_err=1; a read of 0x1000 is unaffected.
  - Read 0x1FFC -> in range, mem_err=0.
- Protocol violations:
  - read+write together -> mem_err=1, rdata=0, proto_err=1 and stays set.
  - Address changed mid-WAIT -> proto_err=1; completes at the original address.
- Reset mid-op: write 0xCAFEF00D to 0x20 (prior 0), rst pulsed in WAIT -> no mem_resp, all outputs 0 next cycle. Subsequent read of 0x20 returns 0.
